// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake into the instruction memory loader.
// The master drives data/valid; the slave (loader) drives ready.
interface instr_mem_loader_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] loader_in_data;
  logic                  loader_in_valid;
  logic                  loader_in_ready;

  modport master (
    output loader_in_data,
    output loader_in_valid,
    input  loader_in_ready
  );

  modport slave (
    input  loader_in_data,
    input  loader_in_valid,
    output loader_in_ready
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader. Receives a frame of
// [length, N program bytes, checksum], writes the program bytes from
// address 0 and releases the core only when the checksum matches.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  loader_clk,
  input  logic                  loader_rst,
  input  logic                  loader_start,
  instr_mem_loader_if.slave     loader_in,
  output logic                  loader_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] loader_mem_addr,
  output logic [DATA_WIDTH-1:0] loader_mem_data,
  output logic                  loader_core_run,
  output logic                  loader_busy,
  output logic                  loader_error,
  output logic [ADDR_WIDTH:0]   loader_byte_count
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  // Length byte 0 encodes a full-depth program.
  localparam logic [ADDR_WIDTH:0] FullDepth = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  in_ready;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] len_trunc;
  logic [ADDR_WIDTH:0]   count_inc;

  // Ready is a pure state decode so it never loops back through valid.
  assign in_ready  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept    = loader_in.loader_in_valid && in_ready;
  assign len_trunc = ADDR_WIDTH'(loader_in.loader_in_data);
  assign count_inc = count_q + 1'b1;

  // Next-state logic for the frame FSM, checksum, counters and write port.
  always_comb begin
    state_d = state_q;
    csum_d  = csum_q;
    count_d = count_q;
    len_d   = len_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (loader_start) begin
          state_d = StLen;
          csum_d  = '0;
          count_d = '0;
        end
      end
      StLen: begin
        if (accept) begin
          len_d   = (len_trunc == '0) ? FullDepth : {1'b0, len_trunc};
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          wr_en_d = 1'b1;
          addr_d  = count_q[ADDR_WIDTH-1:0];
          wdata_d = loader_in.loader_in_data;
          csum_d  = csum_q + loader_in.loader_in_data;
          count_d = count_inc;
          if (count_inc == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (loader_in.loader_in_data == csum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge loader_clk) begin
    if (!loader_rst) begin
      state_q <= StIdle;
      csum_q  <= '0;
      count_q <= '0;
      len_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      csum_q  <= csum_d;
      count_q <= count_d;
      len_q   <= len_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign loader_in.loader_in_ready = in_ready;
  assign loader_mem_wr_en          = wr_en_q;
  assign loader_mem_addr           = addr_q;
  assign loader_mem_data           = wdata_q;
  assign loader_core_run           = (state_q == StDone);
  assign loader_busy               = in_ready;
  assign loader_error              = (state_q == StErr);
  assign loader_byte_count         = count_q;

endmodule
